// File: rtl/uart_pkg.sv
// Shared UART types and line levels used by the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit clock divider: bit_end pulses in the last clk of every CLKS_PER_BIT-clk bit period.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer fed from a first-word-fall-through FIFO read port.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);

  tx_state_e state_q, state_d;

  logic                 bit_end;
  logic                 last_stop;
  logic                 pop;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic                 par_en_q, par_en_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 txd_q, txd_d;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state_q == TX_IDLE) || (state_d != state_q)),
    .bit_end(bit_end)
  );

  assign last_stop = (state_q == TX_STOP) && bit_end && (stop_idx_q == 1'(STOP_BITS - 1));

  // rst_n gating keeps the pop strobe quiet while reset holds the FSM in IDLE.
  assign pop = rst_n && tx_en && !fifo_empty && ((state_q == TX_IDLE) || last_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE:   if (pop) state_d = TX_START;
      TX_START:  if (bit_end) state_d = TX_DATA;
      TX_DATA: begin
        if (bit_end && (bit_idx_q == IdxW'(DATA_BITS - 1))) begin
          state_d = par_en_q ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: if (bit_end) state_d = TX_STOP;
      TX_STOP:   if (last_stop) state_d = pop ? TX_START : TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = pop;
    busy       = (state_q != TX_IDLE) || pop;
    frame_done = last_stop;
    txd        = txd_q;
    txd_d      = UART_IDLE_LVL;
    unique case (state_d)
      TX_IDLE:   txd_d = UART_IDLE_LVL;
      TX_START:  txd_d = UART_START_LVL;
      TX_DATA:   txd_d = shreg_d[0];
      TX_PARITY: txd_d = parity_q;
      TX_STOP:   txd_d = UART_IDLE_LVL;
      default:   txd_d = UART_IDLE_LVL;
    endcase
  end

  always_comb begin
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    par_en_d   = par_en_q;
    bit_idx_d  = '0;
    stop_idx_d = 1'b0;
    if (pop) begin
      shreg_d  = fifo_rd_data;
      parity_d = (^fifo_rd_data) ^ parity_odd;
      par_en_d = parity_en;
    end else if ((state_q == TX_DATA) && bit_end) begin
      shreg_d = shreg_q >> 1;
    end
    if (state_q == TX_DATA) bit_idx_d = bit_end ? bit_idx_q + 1'b1 : bit_idx_q;
    if (state_q == TX_STOP) stop_idx_d = bit_end ? ~stop_idx_q : stop_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      par_en_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= UART_IDLE_LVL;
    end else begin
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      par_en_q   <= par_en_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with a small behavioural FIFO in front of it.
module tb_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en, txd, busy, frame_done;

  logic       tx_en2 = 1'b0;
  logic       fifo2_empty = 1'b1;
  logic [7:0] fifo2_data = 8'hA5;
  logic       fifo2_rd_en, txd2, busy2, frame_done2;

  logic [7:0] mem [8];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pops = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_rd_data = mem[rd_ptr[2:0]];

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .txd         (txd),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en2),
    .parity_en   (1'b0),
    .parity_odd  (1'b0),
    .fifo_empty  (fifo2_empty),
    .fifo_rd_data(fifo2_data),
    .fifo_rd_en  (fifo2_rd_en),
    .txd         (txd2),
    .busy        (busy2),
    .frame_done  (frame_done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[2:0]] = d;
    wr_ptr++;
  endtask

  // Frame bit idx: 0 start, 1..8 data LSB first, 9 parity when enabled, then stop bits.
  function automatic logic frame_bit(input logic [7:0] d, input bit pe, input bit po, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && pe) return (^d) ^ po;
    return 1'b1;
  endfunction

  task automatic wait_pop(input string tag);
    int n;
    n = 0;
    #1;
    while (!fifo_rd_en && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_pop"}, 32'(fifo_rd_en), 32'd1);
  endtask

  // Called in the pop slot; checks every clk of nf frames that follow it.
  task automatic check_stream(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                              input int nf, input bit pe, input bit po, input int drop_at);
    int L, f, kk;
    logic [7:0] d;
    L = (10 + int'(pe)) * C;
    for (int k = 1; k <= nf * L; k++) begin
      tick();
      if (k == drop_at) begin
        tx_en = 1'b0;
        push(8'h55);
        #1;
      end
      f  = (k - 1) / L;
      kk = (k - 1) % L;
      d  = (f == 0) ? d0 : d1;
      chk($sformatf("%s_txd_k%0d", tag, k), 32'(txd), 32'(frame_bit(d, pe, po, kk / C)));
      chk($sformatf("%s_done_k%0d", tag, k), 32'(frame_done), 32'(kk == L - 1));
      chk($sformatf("%s_rden_k%0d", tag, k), 32'(fifo_rd_en), 32'((kk == L - 1) && (f < nf - 1)));
      chk($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int p0, bad_rd, bad_txd, bad_busy, n;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // Reset state
    tick();
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_rden", 32'(fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_txd2", 32'(txd2), 32'd1);
    chk("rst_busy2", 32'(busy2), 32'd0);
    tick();
    rst_n = 1'b1;
    tx_en = 1'b1;

    // Empty FIFO: nothing happens for 100 clks
    bad_rd = 0; bad_txd = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_rd_en !== 1'b0) bad_rd++;
      if (txd !== 1'b1) bad_txd++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("empty_rden_cnt", 32'(bad_rd), 32'd0);
    chk("empty_txd_cnt", 32'(bad_txd), 32'd0);
    chk("empty_busy_cnt", 32'(bad_busy), 32'd0);

    // 0xA5, parity off
    p0 = pops;
    push(8'hA5);
    wait_pop("a5");
    check_stream("a5", 8'hA5, 8'h00, 1, 1'b0, 1'b0, 0);
    chk("a5_pops", 32'(pops - p0), 32'd1);

    // 0xA5, even then odd parity
    tick();
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push(8'hA5);
    wait_pop("a5e");
    check_stream("a5e", 8'hA5, 8'h00, 1, 1'b1, 1'b0, 0);
    tick();
    parity_odd = 1'b1;
    push(8'hA5);
    wait_pop("a5o");
    check_stream("a5o", 8'hA5, 8'h00, 1, 1'b1, 1'b1, 0);

    // Back-to-back 0x00, 0xFF
    tick();
    parity_en = 1'b0;
    parity_odd = 1'b0;
    p0 = pops;
    push(8'h00);
    push(8'hFF);
    wait_pop("b2b");
    check_stream("b2b", 8'h00, 8'hFF, 2, 1'b0, 1'b0, 0);
    tick();
    chk("b2b_pops", 32'(pops - p0), 32'd2);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_txd", 32'(txd), 32'd1);

    // tx_en dropped during DATA of 0x3C (0x55 queued meanwhile)
    p0 = pops;
    push(8'h3C);
    wait_pop("drop");
    check_stream("drop", 8'h3C, 8'h00, 1, 1'b0, 1'b0, 4 * C + 2);
    bad_rd = 0; bad_busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fifo_rd_en !== 1'b0) bad_rd++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("drop_rden_cnt", 32'(bad_rd), 32'd0);
    chk("drop_busy_cnt", 32'(bad_busy), 32'd0);
    chk("drop_pops", 32'(pops - p0), 32'd1);

    // Reset during data bit 3 of 0x55; 0x96 must follow intact
    push(8'h96);
    tx_en = 1'b1;
    wait_pop("rst");
    for (int k = 1; k <= 18; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", 32'(txd), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rden", 32'(fifo_rd_en), 32'd0);
    p0 = pops;
    tick();
    tick();
    chk("rst_hold_pops", 32'(pops - p0), 32'd0);
    rst_n = 1'b1;
    wait_pop("rst_rel");
    check_stream("after_rst", 8'h96, 8'h00, 1, 1'b0, 1'b0, 0);
    chk("after_rst_pops", 32'(pops - p0), 32'd1);

    // STOP_BITS=2 instance: 0xA5 frame of 44 clks, stop high 8 clks
    tick();
    fifo2_empty = 1'b0;
    tx_en2 = 1'b1;
    #1;
    n = 0;
    while (!fifo2_rd_en && n < 30) begin
      tick();
      n++;
    end
    chk("stop2_pop", 32'(fifo2_rd_en), 32'd1);
    for (int k = 1; k <= 11 * C; k++) begin
      tick();
      if (k == 1) fifo2_empty = 1'b1;
      chk($sformatf("stop2_txd_k%0d", k), 32'(txd2), 32'(frame_bit(8'hA5, 1'b0, 1'b0, (k - 1) / C)));
      chk($sformatf("stop2_done_k%0d", k), 32'(frame_done2), 32'(k == 11 * C));
    end
    tick();
    chk("stop2_idle_busy", 32'(busy2), 32'd0);
    chk("stop2_idle_txd", 32'(txd2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
